// File: rtl/vga_rx_pkg.sv
// Shared types and nominal 640x480@60 timing for the VGA receive-side timing decoder.
package vga_rx_pkg;

  localparam int H_TOTAL_DEF     = 800;
  localparam int V_TOTAL_DEF     = 525;
  localparam int H_ACTIVE_DEF    = 640;
  localparam int V_ACTIVE_DEF    = 480;
  localparam int CW_DEF          = 10;
  localparam int LOCK_FRAMES_DEF = 2;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_CHECK    = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

endpackage

// File: rtl/vga_rx_timing_decoder_sync_edge_detect.sv
// Two-stage register on an active-low sync input with a one-cycle falling-edge pulse.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic fall
);

  logic s1, s2;

  // Both stages clear to 0 so no falling edge can be reported straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign fall = s2 & ~s1;

endmodule

// File: rtl/vga_rx_timing_decoder.sv
// Samples a VGA stream, recovers active-pixel coordinates, measures line/frame periods
// and tracks lock against nominal timing. Pin-to-output latency is a fixed 2 clocks.
module vga_rx_timing_decoder
  import vga_rx_pkg::*;
#(
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int CW          = CW_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vga_hs,
  input  logic          vga_vs,
  input  logic          vga_blank_n,
  input  logic [23:0]   vga_rgb,
  output logic          pix_valid,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic [23:0]   pix_rgb,
  output logic          line_start,
  output logic          frame_start,
  output logic          locked,
  output logic          sync_error,
  output logic [CW-1:0] h_meas,
  output logic [CW-1:0] v_meas,
  output state_t        dbg_state
);

  localparam int GW = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES + 1) : 1;
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] CMAX    = '1;
  localparam logic [CW-1:0] CMAX_M1 = CMAX - ONE;
  localparam logic [CW-1:0] H_TOT_C = CW'(H_TOTAL);
  localparam logic [CW-1:0] V_TOT_C = CW'(V_TOTAL);
  localparam logic [CW-1:0] H_ACT_C = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C = CW'(V_ACTIVE);
  localparam logic [GW-1:0] LOCK_C  = GW'(LOCK_FRAMES);

  logic          hs_fall, vs_fall;
  logic          blank_r;
  logic [23:0]   rgb_r;
  logic [CW-1:0] h_cnt, v_cnt, x_cnt, y_cnt;
  logic [CW-1:0] x_cur, v_period;
  logic          seen_hs, seen_vs, line_act;
  logic          h_mis, v_mis, h_lost;

  state_t        state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic          err_d;

  sync_edge_detect u_hs (.clk(clk), .reset(reset), .d(vga_hs), .fall(hs_fall));
  sync_edge_detect u_vs (.clk(clk), .reset(reset), .d(vga_vs), .fall(vs_fall));

  // h_cnt restarts at 1 so that at the next HS fall it equals the period in clocks.
  assign x_cur    = hs_fall ? '0 : x_cnt;
  assign v_period = (hs_fall && v_cnt != CMAX) ? v_cnt + ONE : v_cnt;
  assign h_mis    = hs_fall && seen_hs && (h_cnt != H_TOT_C);
  assign v_mis    = vs_fall && (v_period != V_TOT_C);
  assign h_lost   = !hs_fall && (h_cnt == CMAX_M1);

  // pix_valid qualifies pix_x/pix_y/pix_rgb for exactly one cycle; there is no backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      blank_r     <= 1'b0;
      rgb_r       <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      seen_hs     <= 1'b0;
      seen_vs     <= 1'b0;
      line_act    <= 1'b0;
      h_meas      <= '0;
      v_meas      <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
    end else begin
      blank_r     <= vga_blank_n;
      rgb_r       <= vga_rgb;
      line_start  <= hs_fall;
      frame_start <= vs_fall;

      if (hs_fall) begin
        h_cnt   <= ONE;
        seen_hs <= 1'b1;
        if (seen_hs) h_meas <= h_cnt;
      end else if (h_cnt != CMAX) begin
        h_cnt <= h_cnt + ONE;
      end

      // An HS fall coincident with the VS fall belongs to the frame being closed.
      if (vs_fall) begin
        v_cnt   <= '0;
        seen_vs <= 1'b1;
        if (seen_vs) v_meas <= v_period;
      end else if (hs_fall && v_cnt != CMAX) begin
        v_cnt <= v_cnt + ONE;
      end

      pix_valid <= blank_r && (x_cur < H_ACT_C) && (y_cnt < V_ACT_C);
      pix_x     <= x_cur;
      pix_y     <= y_cnt;
      pix_rgb   <= rgb_r;

      if (blank_r && x_cur != CMAX) x_cnt <= x_cur + ONE;
      else                          x_cnt <= x_cur;

      if (hs_fall)      line_act <= blank_r;
      else if (blank_r) line_act <= 1'b1;

      if (vs_fall)                                  y_cnt <= '0;
      else if (hs_fall && line_act && y_cnt != CMAX) y_cnt <= y_cnt + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_UNLOCKED;
      good_q     <= '0;
      sync_error <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_q     <= good_d;
      sync_error <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_d   = 1'b0;
    case (state_q)
      ST_UNLOCKED: begin
        if (vs_fall) begin
          state_d = ST_CHECK;
          good_d  = '0;
        end
      end
      ST_CHECK: begin
        if (h_mis) begin
          state_d = ST_UNLOCKED;
          good_d  = '0;
        end else if (vs_fall) begin
          if (v_mis) begin
            good_d = '0;
          end else begin
            good_d = good_q + GW'(1);
            if (good_d == LOCK_C) state_d = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        // A line fault outranks a frame fault; either way only one error pulse is raised.
        if (h_mis || h_lost) begin
          err_d   = 1'b1;
          state_d = ST_UNLOCKED;
          good_d  = '0;
        end else if (v_mis) begin
          err_d   = 1'b1;
          state_d = ST_CHECK;
          good_d  = '0;
        end
      end
      default: begin
        state_d = ST_UNLOCKED;
        good_d  = '0;
      end
    endcase
  end

  always_comb begin
    locked    = (state_q == ST_LOCKED);
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_vga_rx_timing_decoder.sv
// Bench for vga_rx_timing_decoder on a scaled-down raster (40x30 total, 24x16 active).
module tb_vga_rx_timing_decoder;
  import vga_rx_pkg::*;

  localparam int HT = 40, VT = 30, HA = 24, VA = 16, CW = 10, LF = 2;
  localparam int HS_W = 4, H_ACT0 = 8, VS_W = 2, V_ACT0 = 5, RST_H = 35;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vga_hs = 1'b1, vga_vs = 1'b1, vga_blank_n = 1'b0;
  logic [23:0]   vga_rgb = '0;
  logic          pix_valid, line_start, frame_start, locked, sync_error;
  logic [CW-1:0] pix_x, pix_y, h_meas, v_meas;
  logic [23:0]   pix_rgb;
  state_t        dbg_state;

  vga_rx_timing_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA), .CW(CW), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .reset(reset), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_rgb(vga_rgb), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .line_start(line_start), .frame_start(frame_start), .locked(locked),
    .sync_error(sync_error), .h_meas(h_meas), .v_meas(v_meas), .dbg_state(dbg_state)
  );

  // clock / reset bookkeeping
  always #5 clk = ~clk;
  int   cyc = 0;
  logic rst_d = 1'b0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= reset;
  end

  // scoreboard queues: pixel {rgb,y,x,cyc}; error {sel,meas,hi,lo}; frame {hchk,h,vchk,v,cyc}; lock cyc
  logic [59:0] exp_q[$];
  logic [43:0] err_q[$];
  logic [37:0] fs_q[$];
  logic [15:0] lock_q[$];
  int n_tests = 0, n_fail = 0;
  int lines_driven = 0, last_hs_cyc = 0;
  bit done = 1'b0, blank_rest = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    vga_hs = 1'b1; vga_vs = 1'b1; vga_blank_n = 1'b0;
    repeat (n) begin
      vga_rgb = 24'($urandom);
      tick();
    end
  endtask

  task automatic drive_frame(input int vt, input int long_line, input int rst_line,
                             input bit exp_lock, input int err_v, input int fs_v, input int fs_h);
    int ht;
    bit act;
    logic [9:0] x, y;
    for (int v = 0; v < vt; v++) begin
      ht = (v == long_line) ? HT + 1 : HT;
      for (int h = 0; h < ht; h++) begin
        act = (h >= H_ACT0) && (h < H_ACT0 + HA) && (v >= V_ACT0) && (v < V_ACT0 + VA) && !blank_rest;
        x = 10'(h - H_ACT0);
        y = 10'(v - V_ACT0);
        vga_hs      = (h >= HS_W);
        vga_vs      = (v >= VS_W);
        vga_blank_n = act;
        vga_rgb     = act ? {2'b00, x, 2'b00, y} : 24'($urandom);
        reset       = (v == rst_line) && (h == RST_H);
        if (reset) blank_rest = 1'b1;
        if (act) exp_q.push_back({vga_rgb, y, x, 16'(cyc + 2)});
        if (h == 0) begin
          lines_driven++;
          last_hs_cyc = cyc;
        end
        if (h == 0 && v == 0) begin
          fs_q.push_back({fs_h != 0, 10'(fs_h), fs_v != 0, 10'(fs_v), 16'(cyc + 2)});
          if (exp_lock) lock_q.push_back(16'(cyc + 2));
          if (err_v != 0) err_q.push_back({2'd2, 10'(err_v), 16'(cyc + 2), 16'(cyc + 2)});
        end
        if (long_line >= 0 && v == long_line + 1 && h == 0)
          err_q.push_back({2'd1, 10'(HT + 1), 16'(cyc + 2), 16'(cyc + 2)});
        tick();
      end
    end
    reset      = 1'b0;
    blank_rest = 1'b0;
  endtask

  // HS disappears; the error must land about 1023 clocks after the last HS fall.
  task automatic hs_lost(input int n);
    err_q.push_back({2'd0, 10'd0, 16'(last_hs_cyc + 1028), 16'(last_hs_cyc + 1020)});
    idle(n);
  endtask

  // driver
  initial begin
    reset = 1'b1;
    repeat (4) tick();
    reset = 1'b0;
    idle(5);
    drive_frame(VT, -1, -1, 1'b0, 0, 0, 0);
    drive_frame(VT, -1, -1, 1'b0, 0, VT, HT);
    drive_frame(VT, -1, -1, 1'b1, 0, VT, HT);
    drive_frame(VT, -1, -1, 1'b0, 0, VT, HT);
    drive_frame(VT, 7, -1, 1'b0, 0, VT, HT);
    drive_frame(VT, -1, -1, 1'b0, 0, VT, HT);
    drive_frame(VT, -1, -1, 1'b0, 0, VT, HT);
    drive_frame(VT, -1, -1, 1'b1, 0, VT, HT);
    drive_frame(VT + 1, -1, -1, 1'b0, 0, VT, HT);
    drive_frame(VT, -1, -1, 1'b0, VT + 1, VT + 1, HT);
    drive_frame(VT, -1, -1, 1'b0, 0, VT, HT);
    drive_frame(VT, -1, -1, 1'b1, 0, VT, HT);
    hs_lost(1100);
    drive_frame(VT, -1, -1, 1'b0, 0, VT, 1023);
    drive_frame(VT, -1, -1, 1'b0, 0, VT, HT);
    drive_frame(VT, -1, -1, 1'b1, 0, VT, HT);
    drive_frame(VT, -1, 10, 1'b0, 0, VT, HT);
    drive_frame(VT, -1, -1, 1'b0, 0, 0, HT);
    drive_frame(VT, -1, -1, 1'b0, 0, VT, HT);
    drive_frame(VT, -1, -1, 1'b1, 0, VT, HT);
    drive_frame(VT, -1, -1, 1'b0, 0, VT, HT);
    idle(10);
    done = 1'b1;
  end

  // monitor + final report
  initial begin
    logic [59:0] pe;
    logic [43:0] ee;
    logic [37:0] fe;
    logic [15:0] le;
    logic        prev_locked;
    int          ls_count;
    prev_locked = 1'b0;
    ls_count    = 0;
    forever begin
      @(negedge clk);
      if (done) begin
        n_tests++;
        if (exp_q.size() != 0) begin
          n_fail++; $display("FAIL pixels_missing: got %0d left, want 0", exp_q.size());
        end
        n_tests++;
        if (err_q.size() != 0) begin
          n_fail++; $display("FAIL sync_error_missing: got %0d left, want 0", err_q.size());
        end
        n_tests++;
        if (fs_q.size() != 0) begin
          n_fail++; $display("FAIL frame_start_missing: got %0d left, want 0", fs_q.size());
        end
        n_tests++;
        if (lock_q.size() != 0) begin
          n_fail++; $display("FAIL lock_missing: got %0d left, want 0", lock_q.size());
        end
        n_tests++;
        if (ls_count != lines_driven) begin
          n_fail++; $display("FAIL line_start_count: got %0d, want %0d", ls_count, lines_driven);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
      if (rst_d) begin
        n_tests++;
        if ({pix_valid, pix_x, pix_y, pix_rgb, line_start, frame_start, locked, sync_error,
             h_meas, v_meas} != '0) begin
          n_fail++;
          $display("FAIL reset_outputs: got valid=%b x=%0d y=%0d rgb=%h ls=%b fs=%b lk=%b err=%b hm=%0d vm=%0d, want all 0",
                   pix_valid, pix_x, pix_y, pix_rgb, line_start, frame_start, locked, sync_error, h_meas, v_meas);
        end
      end
      if (line_start) ls_count++;
      if (pix_valid) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL pixel_unexpected: got x=%0d y=%0d at %0d, want none", pix_x, pix_y, cyc);
        end else begin
          pe = exp_q.pop_front();
          if (pix_x != pe[25:16] || pix_y != pe[35:26] || pix_rgb != pe[59:36] || cyc[15:0] != pe[15:0]) begin
            n_fail++;
            $display("FAIL pixel: got x=%0d y=%0d rgb=%h t=%0d, want x=%0d y=%0d rgb=%h t=%0d",
                     pix_x, pix_y, pix_rgb, cyc[15:0], pe[25:16], pe[35:26], pe[59:36], pe[15:0]);
          end
        end
      end
      if (frame_start) begin
        n_tests++;
        if (fs_q.size() == 0) begin
          n_fail++; $display("FAIL frame_start_unexpected: got pulse at %0d, want none", cyc);
        end else begin
          fe = fs_q.pop_front();
          if (cyc[15:0] != fe[15:0] || (fe[26] && v_meas != fe[25:16]) || (fe[37] && h_meas != fe[36:27])) begin
            n_fail++;
            $display("FAIL frame_start: got t=%0d v_meas=%0d h_meas=%0d, want t=%0d v_meas=%0d h_meas=%0d",
                     cyc[15:0], v_meas, h_meas, fe[15:0], fe[25:16], fe[36:27]);
          end
        end
      end
      if (sync_error) begin
        n_tests++;
        if (err_q.size() == 0) begin
          n_fail++; $display("FAIL sync_error_unexpected: got pulse at %0d, want none", cyc);
        end else begin
          ee = err_q.pop_front();
          if (cyc[15:0] < ee[15:0] || cyc[15:0] > ee[31:16] || locked ||
              (ee[43:42] == 2'd1 && h_meas != ee[41:32]) ||
              (ee[43:42] == 2'd2 && v_meas != ee[41:32]) ||
              (ee[43:42] == 2'd2 && dbg_state != ST_CHECK) ||
              (ee[43:42] != 2'd2 && dbg_state != ST_UNLOCKED)) begin
            n_fail++;
            $display("FAIL sync_error: got t=%0d locked=%b h_meas=%0d v_meas=%0d state=%0d, want t=%0d..%0d locked=0 meas=%0d kind=%0d",
                     cyc[15:0], locked, h_meas, v_meas, dbg_state, ee[15:0], ee[31:16], ee[41:32], ee[43:42]);
          end
        end
      end
      if (locked && !prev_locked) begin
        n_tests++;
        if (lock_q.size() == 0) begin
          n_fail++; $display("FAIL lock_unexpected: got rise at %0d, want none", cyc);
        end else begin
          le = lock_q.pop_front();
          if (cyc[15:0] != le || dbg_state != ST_LOCKED) begin
            n_fail++;
            $display("FAIL lock_rise: got t=%0d state=%0d, want t=%0d state=%0d", cyc[15:0], dbg_state, le, ST_LOCKED);
          end
        end
      end
      if (!locked && prev_locked) begin
        n_tests++;
        if (!sync_error && !rst_d) begin
          n_fail++; $display("FAIL lock_drop: got drop without cause at %0d, want sync_error or reset", cyc);
        end
      end
      prev_locked = locked;
    end
  end

endmodule
